vram_oam_arbiter: RTL

VRAM_OAM_ARBITER -- requirements
Module: vram_oam_arbiter

---
 rtl/ppu_pkg.sv | 40 ++++
 rtl/vram_oam_arbiter_if.sv | 34 +++
 rtl/oam_dma_engine.sv | 71 +++++++
 rtl/vram_oam_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU/arbiter types: PPU mode, OAM DMA state, port owner and the
// address map of the VRAM/OAM regions.
package ppu_pkg;

   typedef enum logic [1:0] {
      H_BLANK = 2'd0,
      V_BLANK = 2'd1,
      SCAN    = 2'd2,
      DRAW    = 2'd3
   } ppu_mode_e;

   typedef enum logic [1:0] {
      D_IDLE  = 2'd0,
      D_START = 2'd1,
      D_READ  = 2'd2,
      D_WRITE = 2'd3
   } dma_state_e;

   typedef enum logic [1:0] {
      O_NONE = 2'd0,
      O_DMA  = 2'd1,
      O_PPU  = 2'd2,
      O_CPU  = 2'd3
   } owner_e;

   localparam logic [15:0] VRAM_LO = 16'h8000;
   localparam logic [15:0] VRAM_HI = 16'h9FFF;
   localparam logic [15:0] OAM_LO  = 16'hFE00;
   localparam logic [15:0] OAM_HI  = 16'hFE9F;
   localparam logic [15:0] DMA_REG = 16'hFF46;

   function automatic logic in_vram(input logic [15:0] a);
      return (a >= VRAM_LO) && (a <= VRAM_HI);
   endfunction

   function automatic logic in_oam(input logic [15:0] a);
      return (a >= OAM_LO) && (a <= OAM_HI);
   endfunction

endpackage

// File: rtl/vram_oam_arbiter_if.sv
// Bus bundle around the arbiter: CPU MMIO side, PPU fetch side and the single
// shared VRAM+OAM memory port. master = surrounding system, slave = arbiter.
interface vram_oam_arbiter_if;

   logic [15:0] ADDR;
   logic        WR;
   logic        RD;
   logic [7:0]  MMIO_DATA_out;
   logic [7:0]  MMIO_DATA_in;

   logic [1:0]  PPU_MODE;
   logic        PPU_RD;
   logic [15:0] PPU_ADDR;
   logic [7:0]  PPU_DATA_in;

   logic [15:0] MEM_ADDR;
   logic        MEM_RD;
   logic        MEM_WR;
   logic [7:0]  MEM_WDATA;
   logic [7:0]  MEM_RDATA;

   logic        DMA_ACTIVE;

   modport master (
      output ADDR, WR, RD, MMIO_DATA_out, PPU_MODE, PPU_RD, PPU_ADDR, MEM_RDATA,
      input  MMIO_DATA_in, PPU_DATA_in, MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA, DMA_ACTIVE
   );

   modport slave (
      input  ADDR, WR, RD, MMIO_DATA_out, PPU_MODE, PPU_RD, PPU_ADDR, MEM_RDATA,
      output MMIO_DATA_in, PPU_DATA_in, MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA, DMA_ACTIVE
   );

endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: copies DMA_LEN bytes from {src_hi, idx} to OAM_BASE+idx,
// one read cycle and one write cycle per byte, after a single start delay.
module oam_dma_engine
   import ppu_pkg::*;
#(
   parameter int          DMA_LEN  = 160,
   parameter logic [15:0] OAM_BASE = 16'hFE00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  start_hi,
   input  logic [7:0]  mem_rdata,
   output logic        active,
   output logic        owns_port,
   output logic        dma_rd,
   output logic        dma_wr,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_wdata
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_e state_q;
   dma_state_e state_d;
   logic [7:0] idx_q;
   logic [7:0] src_hi_q;

   // A start request restarts from idx 0 regardless of where the transfer is;
   // source pages above DF are folded down by 0x20 when latched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= D_IDLE;
         idx_q    <= 8'h00;
         src_hi_q <= 8'h00;
      end else begin
         state_q <= state_d;
         if (start) begin
            idx_q    <= 8'h00;
            src_hi_q <= (start_hi > 8'hDF) ? (start_hi - 8'h20) : start_hi;
         end else if (state_q == D_WRITE) begin
            idx_q <= idx_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         D_START: state_d = D_READ;
         D_READ:  state_d = D_WRITE;
         D_WRITE: state_d = (idx_q < LAST_IDX) ? D_READ : D_IDLE;
         default: state_d = D_IDLE;
      endcase
      if (start) begin
         state_d = D_START;
      end
   end

   // The byte read in D_READ arrives on mem_rdata during D_WRITE, so it is
   // forwarded straight to the write data.
   always_comb begin
      active    = (state_q != D_IDLE);
      owns_port = (state_q == D_READ) || (state_q == D_WRITE);
      dma_rd    = (state_q == D_READ);
      dma_wr    = (state_q == D_WRITE);
      dma_addr  = (state_q == D_WRITE) ? (OAM_BASE + {8'h00, idx_q}) : {src_hi_q, idx_q};
      dma_wdata = mem_rdata;
   end

endmodule

// File: rtl/vram_oam_arbiter.sv
// Shares one VRAM+OAM memory port between OAM DMA, PPU fetches and CPU MMIO,
// applies PPU-mode access blocking and steers read data back to its requester.
module vram_oam_arbiter
   import ppu_pkg::*;
#(
   parameter int          DMA_LEN  = 160,
   parameter logic [15:0] OAM_BASE = 16'hFE00
) (
   input logic               clk,
   input logic               rst,
   vram_oam_arbiter_if.slave bus
);

   ppu_mode_e   mode;
   logic        dma_start;
   logic        dma_active;
   logic        dma_owns;
   logic        dma_rd;
   logic        dma_wr;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;

   logic        ppu_req;
   logic        cpu_req;
   logic        cpu_allowed;
   logic        cpu_rd_lost;
   owner_e      grant;
   owner_e      owner_q;
   logic        blocked_q;

   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] addr_d;
   logic [15:0] addr_q;
   logic [7:0]  wdata_d;
   logic [7:0]  wdata_q;
   logic [7:0]  mmio_rdata;
   logic [7:0]  ppu_rdata;

   assign mode      = ppu_mode_e'(bus.PPU_MODE);
   assign dma_start = bus.WR && (bus.ADDR == DMA_REG);

   oam_dma_engine #(
      .DMA_LEN  (DMA_LEN),
      .OAM_BASE (OAM_BASE)
   ) u_dma (
      .clk       (clk),
      .rst       (rst),
      .start     (dma_start),
      .start_hi  (bus.MMIO_DATA_out),
      .mem_rdata (bus.MEM_RDATA),
      .active    (dma_active),
      .owns_port (dma_owns),
      .dma_rd    (dma_rd),
      .dma_wr    (dma_wr),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata)
   );

   // Fixed priority DMA > PPU > CPU. Nothing is granted while rst is high so a
   // reset in the middle of a transfer cannot leak one more OAM write.
   always_comb begin
      ppu_req     = bus.PPU_RD && ((mode == SCAN) || (mode == DRAW));
      cpu_req     = bus.WR || bus.RD;
      cpu_allowed = (in_vram(bus.ADDR) && (mode != DRAW)) ||
                    (in_oam(bus.ADDR) && (mode != SCAN) && (mode != DRAW) && !dma_active);
      grant = O_NONE;
      if (!rst) begin
         if (dma_owns) begin
            grant = O_DMA;
         end else if (ppu_req) begin
            grant = O_PPU;
         end else if (cpu_req && cpu_allowed) begin
            grant = O_CPU;
         end
      end
      cpu_rd_lost = bus.RD && !bus.WR && (grant != O_CPU);
   end

   // Address and write data keep their last driven value while nobody owns
   // the port.
   always_comb begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (grant)
         O_DMA: begin
            mem_rd = dma_rd;
            mem_wr = dma_wr;
            addr_d = dma_addr;
            if (dma_wr) begin
               wdata_d = dma_wdata;
            end
         end
         O_PPU: begin
            mem_rd = 1'b1;
            addr_d = bus.PPU_ADDR;
         end
         O_CPU: begin
            addr_d = bus.ADDR;
            if (bus.WR) begin
               mem_wr  = 1'b1;
               wdata_d = bus.MMIO_DATA_out;
            end else begin
               mem_rd = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // A granted CPU write has no read data to return, so it is recorded as
   // no reader; everything else records who gets next cycle's MEM_RDATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q   <= O_NONE;
         blocked_q <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 8'h00;
      end else begin
         owner_q   <= ((grant == O_CPU) && bus.WR) ? O_NONE : grant;
         blocked_q <= cpu_rd_lost;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      mmio_rdata = ((owner_q == O_CPU) && !blocked_q) ? bus.MEM_RDATA : 8'hFF;
      ppu_rdata  = (owner_q == O_PPU) ? bus.MEM_RDATA : 8'hFF;
   end

   assign bus.MEM_RD       = mem_rd;
   assign bus.MEM_WR       = mem_wr;
   assign bus.MEM_ADDR     = addr_d;
   assign bus.MEM_WDATA    = wdata_d;
   assign bus.MMIO_DATA_in = mmio_rdata;
   assign bus.PPU_DATA_in  = ppu_rdata;
   assign bus.DMA_ACTIVE   = dma_active;

endmodule
